// File: rtl/cdf_ctrl_if.sv
// Handshake bundle between the equalization FSM / CDF datapath and cdf_ctrl.
// The master side is the controller: it consumes start/hold and drives the
// datapath command strobes and status.
interface cdf_ctrl_if;
  logic       start;
  logic       hold;
  logic       read_first_value_in;
  logic       read_next_value_in;
  logic       scratch_mem_read_ready_in;
  logic       cdf_computation_done_in;
  logic       cdf_done_in;
  logic       busy;
  logic       done;
  logic [7:0] step;

  modport master (
    input  start,
    input  hold,
    output read_first_value_in,
    output read_next_value_in,
    output scratch_mem_read_ready_in,
    output cdf_computation_done_in,
    output cdf_done_in,
    output busy,
    output done,
    output step
  );

  modport slave (
    output start,
    output hold,
    input  read_first_value_in,
    input  read_next_value_in,
    input  scratch_mem_read_ready_in,
    input  cdf_computation_done_in,
    input  cdf_done_in,
    input  busy,
    input  done,
    input  step
  );
endinterface

// File: rtl/cdf_ctrl.sv
// CDF sequencing controller: walks the histogram eight bins per step, issuing
// a read, waiting out the memory/datapath latency, flagging compute-ready and
// strobing two write commits per step. Every output is a flop that is loaded
// together with the state transition, so nothing depends combinationally on
// start or hold.
module cdf_ctrl #(
  parameter int NUM_STEPS = 32,
  parameter int RD_LAT    = 0
) (
  input logic         clk,
  input logic         reset,
  cdf_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ISSUE,
    WAIT,
    READY,
    DONE0,
    DONE1,
    FINISH
  } state_t;

  localparam logic [7:0] LAST_STEP = 8'(NUM_STEPS - 1);
  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT);

  state_t     state;
  logic [7:0] step_q;
  logic [2:0] wait_cnt;
  logic       read_first_q;
  logic       read_next_q;
  logic       read_ready_q;
  logic       commit_q;
  logic       finish_q;
  logic       busy_q;

  // State walk plus output flops; each pulse is set on entry to the state
  // that owns it and cleared by the default on every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      step_q       <= 8'd0;
      wait_cnt     <= 3'd0;
      read_first_q <= 1'b0;
      read_next_q  <= 1'b0;
      read_ready_q <= 1'b0;
      commit_q     <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      read_first_q <= 1'b0;
      read_next_q  <= 1'b0;
      read_ready_q <= 1'b0;
      commit_q     <= 1'b0;
      finish_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= REQ;
            step_q <= 8'd0;
            busy_q <= 1'b1;
          end
        end
        REQ: begin
          if (!bus.hold) begin
            state        <= ISSUE;
            read_first_q <= (step_q == 8'd0);
            read_next_q  <= (step_q != 8'd0);
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state        <= READY;
            read_ready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        READY: begin
          state    <= DONE0;
          commit_q <= 1'b1;
        end
        DONE0: begin
          state    <= DONE1;
          commit_q <= 1'b1;
        end
        DONE1: begin
          if (step_q == LAST_STEP) begin
            state    <= FINISH;
            finish_q <= 1'b1;
          end else begin
            step_q <= step_q + 8'd1;
            state  <= REQ;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_first_value_in       = read_first_q;
  assign bus.read_next_value_in        = read_next_q;
  assign bus.scratch_mem_read_ready_in = read_ready_q;
  assign bus.cdf_computation_done_in   = commit_q;
  assign bus.cdf_done_in               = finish_q;
  assign bus.done                      = finish_q;
  assign bus.busy                      = busy_q;
  assign bus.step                      = step_q;

endmodule

// File: tb/tb_cdf_ctrl.sv
// Directed bench for cdf_ctrl: full default pass with ignored starts, a pass
// with hold in REQ and in WAIT, a mid-pass reset with a coincident start,
// a clean restart, and a single-step RD_LAT=2 instance.
module tb_cdf_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  cdf_ctrl_if bus_a ();
  cdf_ctrl_if bus_b ();

  cdf_ctrl #(.NUM_STEPS(32), .RD_LAT(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  cdf_ctrl #(.NUM_STEPS(1), .RD_LAT(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Cycle (relative to the start cycle C0) of ISSUE for step k, with an
  // optional hold stretch added from step holdStep onward.
  function automatic int issueCyc(int k, int holdStep, int holdLen);
    return 2 + k * 6 + ((k >= holdStep) ? holdLen : 0);
  endfunction

  function automatic bit hitAny(int c, int kFrom, int off, int holdStep, int holdLen);
    for (int k = kFrom; k < 32; k++)
      if (c == issueCyc(k, holdStep, holdLen) + off) return 1'b1;
    return 1'b0;
  endfunction

  // One 32-step pass of dut_a starting at relative cycle 0, checked every cycle.
  task automatic runPass(input int holdStep, input int holdLen, input int waitHold,
                         input int prevStep, input int resetCyc, input bit extraStarts);
    int fin;
    int holdFrom;
    int lastC;
    int nRf, nRn, nRdy, nCd, nDone;
    logic eRf, eRn, eRdy, eCd, eDone, eBusy;
    int eStep;
    bit killed;
    fin      = issueCyc(31, holdStep, holdLen) + 5;
    holdFrom = (holdStep < 32) ? issueCyc(holdStep - 1, holdStep, holdLen) + 5 : -100;
    lastC    = (resetCyc > 0) ? resetCyc + 10 : fin + 2;
    nRf = 0; nRn = 0; nRdy = 0; nCd = 0; nDone = 0;
    cyc = 0;
    for (int c = 0; c <= lastC; c++) begin
      killed = (resetCyc > 0) && (c > resetCyc);
      eRf    = !killed && (c == issueCyc(0, holdStep, holdLen));
      eRn    = !killed && hitAny(c, 1, 0, holdStep, holdLen);
      eRdy   = !killed && hitAny(c, 0, 2, holdStep, holdLen);
      eCd    = !killed && (hitAny(c, 0, 3, holdStep, holdLen) || hitAny(c, 0, 4, holdStep, holdLen));
      eDone  = !killed && (c == fin);
      eBusy  = !killed && (c >= 1) && (c <= fin);
      if (killed) eStep = 0;
      else if (c == 0) eStep = prevStep;
      else begin
        eStep = 0;
        for (int k = 1; k < 32; k++)
          if (c >= issueCyc(k - 1, holdStep, holdLen) + 5) eStep = k;
      end
      checkOutput("read_first", 32'(bus_a.read_first_value_in), 32'(eRf));
      checkOutput("read_next", 32'(bus_a.read_next_value_in), 32'(eRn));
      checkOutput("read_ready", 32'(bus_a.scratch_mem_read_ready_in), 32'(eRdy));
      checkOutput("cdf_commit", 32'(bus_a.cdf_computation_done_in), 32'(eCd));
      checkOutput("cdf_done_in", 32'(bus_a.cdf_done_in), 32'(eDone));
      checkOutput("done", 32'(bus_a.done), 32'(eDone));
      checkOutput("busy", 32'(bus_a.busy), 32'(eBusy));
      checkOutput("step", 32'(bus_a.step), 32'(eStep));
      nRf   += int'(bus_a.read_first_value_in);
      nRn   += int'(bus_a.read_next_value_in);
      nRdy  += int'(bus_a.scratch_mem_read_ready_in);
      nCd   += int'(bus_a.cdf_computation_done_in);
      nDone += int'(bus_a.cdf_done_in);
      bus_a.start = (c == 0) || (extraStarts && (c == 50 || c == fin)) ||
                    ((resetCyc > 0) && (c == resetCyc));
      reset       = (resetCyc > 0) && (c == resetCyc);
      bus_a.hold  = ((c >= holdFrom) && (c < holdFrom + holdLen)) || (c == waitHold);
      applyStimulus();
    end
    bus_a.start = 1'b0;
    bus_a.hold  = 1'b0;
    reset       = 1'b0;
    if (resetCyc == 0) begin
      checkOutput("count_read_first", 32'(nRf), 32'd1);
      checkOutput("count_read_next", 32'(nRn), 32'd31);
      checkOutput("count_read_ready", 32'(nRdy), 32'd32);
      checkOutput("count_commit", 32'(nCd), 32'd64);
      checkOutput("count_cdf_done", 32'(nDone), 32'd1);
    end
  endtask

  // Directed sequence of scenarios, ending in the summary line.
  initial begin
    reset       = 1'b1;
    bus_a.start = 1'b0;
    bus_a.hold  = 1'b0;
    bus_b.start = 1'b0;
    bus_b.hold  = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("reset_busy_a", 32'(bus_a.busy), 32'd0);
    checkOutput("reset_step_a", 32'(bus_a.step), 32'd0);
    checkOutput("reset_done_a", 32'(bus_a.cdf_done_in), 32'd0);
    checkOutput("reset_busy_b", 32'(bus_b.busy), 32'd0);

    $display("[TB] default pass with starts at C50 and in FINISH");
    runPass(99, 0, -1, 0, 0, 1'b1);

    $display("[TB] pass with hold entering step 3 and during step 4 WAIT");
    runPass(3, 5, 32, 31, 0, 1'b0);

    $display("[TB] pass interrupted by reset at C100 with coincident start");
    runPass(99, 0, -1, 31, 100, 1'b0);

    $display("[TB] restart after reset");
    runPass(99, 0, -1, 0, 0, 1'b0);

    $display("[TB] single step, RD_LAT=2");
    cyc = 0;
    for (int c = 0; c <= 11; c++) begin
      checkOutput("b_read_first", 32'(bus_b.read_first_value_in), 32'(c == 2));
      checkOutput("b_read_next", 32'(bus_b.read_next_value_in), 32'd0);
      checkOutput("b_read_ready", 32'(bus_b.scratch_mem_read_ready_in), 32'(c == 6));
      checkOutput("b_commit", 32'(bus_b.cdf_computation_done_in), 32'(c == 7 || c == 8));
      checkOutput("b_cdf_done", 32'(bus_b.cdf_done_in), 32'(c == 9));
      checkOutput("b_done", 32'(bus_b.done), 32'(c == 9));
      checkOutput("b_busy", 32'(bus_b.busy), 32'(c >= 1 && c <= 9));
      checkOutput("b_step", 32'(bus_b.step), 32'd0);
      bus_b.start = (c == 0);
      applyStimulus();
    end
    bus_b.start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
